// File: rtl/jk_arb_pkg.sv
// -----------------------------------------------------------------------------
// jk_arb_pkg
// Shared definitions for the JK bank arbiter:
//   - JK operation encodings (hold / reset / set / toggle)
//   - J/K pair type and the op -> J/K derivation used by the apply stage
// -----------------------------------------------------------------------------
package jk_arb_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef struct packed {
    logic j;
    logic k;
  } jk_pair_t;

  // The op encoding was chosen so that bit 1 is J and bit 0 is K directly.
  function automatic jk_pair_t jk_from_op(input logic [1:0] op);
    jk_pair_t v_jk;
    v_jk.j = op[1];
    v_jk.k = op[0];
    return v_jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
// A single JK flip-flop with asynchronous active-low reset.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous reset, active low (clears o_q)
//   i_j      J input
//   i_k      K input
//   o_q      stored bit
// -----------------------------------------------------------------------------
module jk_cell (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// -----------------------------------------------------------------------------
// jk_bank_arbiter
// Shares a bank of WIDTH JK cells between NREQ requesters. One requester is
// granted per cycle; its op/mask are captured into a command register (stage
// A) and applied to the bank on the following edge (stage B). Both stages run
// concurrently so one command completes per cycle at full load.
//
// Configuration macro:
//   JK_ARB_RR_EN  defined   -> round-robin arbitration with rotating pointer
//                 undefined -> fixed priority, lowest index wins (no pointer)
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous reset, active low
//   req      [NREQ]        level request per requester
//   op       [2*NREQ]      op for requester i at [2i+1:2i]
//   mask     [WIDTH*NREQ]  bit-mask for requester i at [WIDTH*i +: WIDTH]
//   gnt      [NREQ]        registered one-hot grant pulse
//   busy                   command register holds a command to apply
//   upd                    pulse the cycle after a command was applied
//   last_id  [clog2(NREQ)] most recently granted requester
//   q        [WIDTH]       bank state
// -----------------------------------------------------------------------------
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [WIDTH*NREQ-1:0]    mask,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     upd,
  output logic [$clog2(NREQ)-1:0]  last_id,
  output logic [WIDTH-1:0]         q
);

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]  r_gnt;
  logic             r_busy;
  logic             r_upd;
  logic [IDW-1:0]   r_last_id;
  logic [1:0]       r_cmd_op;
  logic [WIDTH-1:0] r_cmd_mask;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  jk_pair_t         w_jk;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  assign w_any = |req;

`ifdef JK_ARB_RR_EN
  logic [IDW-1:0] r_ptr;

  // Scan from the pointer upward, wrapping; first active request wins.
  always_comb begin
    logic v_found;
    int   v_idx;
    w_win   = '0;
    v_found = 1'b0;
    v_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!v_found && req[v_idx]) begin
        v_found = 1'b1;
        w_win   = IDW'(v_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
  end
`else
  // Fixed priority: walking down means the lowest active index is left last.
  always_comb begin
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k]) w_win = IDW'(k);
    end
  end
`endif

  // Stage A: grant and capture the winner's command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_upd      <= 1'b0;
      r_last_id  <= '0;
      r_cmd_op   <= OP_HOLD;
      r_cmd_mask <= '0;
    end else begin
      r_upd <= r_busy;
      if (w_any) begin
        r_gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
        r_busy     <= 1'b1;
        r_last_id  <= w_win;
        r_cmd_op   <= op[2*int'(w_win) +: 2];
        r_cmd_mask <= mask[WIDTH*int'(w_win) +: WIDTH];
      end else begin
        r_gnt  <= '0;
        r_busy <= 1'b0;
      end
    end
  end

  // Stage B: drive the bank from the command register
  assign w_jk = jk_from_op(r_cmd_op);
  assign w_j  = r_busy ? (r_cmd_mask & {WIDTH{w_jk.j}}) : '0;
  assign w_k  = r_busy ? (r_cmd_mask & {WIDTH{w_jk.k}}) : '0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_j     (w_j[gi]),
      .i_k     (w_k[gi]),
      .o_q     (q[gi])
    );
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign upd     = r_upd;
  assign last_id = r_last_id;

endmodule
